// File: rtl/urv_timer_pkg.sv
// Shared constants for the uRV timer block: CSR addresses decoded on the execute-stage write path.
package urv_timer_pkg;

    localparam logic [11:0] CSR_ID_CYCLESL      = 12'hc00;
    localparam logic [11:0] CSR_ID_CYCLESH      = 12'hc80;
    localparam logic [11:0] CSR_ID_TIMER        = 12'hc01;
    localparam logic [11:0] CSR_ID_TIMER_PERIOD = 12'h7c0;

    function automatic logic is_period_write(input logic stall, input logic kill,
                                             input logic is_csr, input logic [11:0] sel);
        return !stall && !kill && is_csr && (sel == CSR_ID_TIMER_PERIOD);
    endfunction

endpackage

// File: rtl/urv_timer_if.sv
// CSR write path into the timer and CSR read values back out; names are from the timer's point of view.
interface urv_timer_if;
    logic        x_stall_i;
    logic        x_kill_i;
    logic        d_is_csr_i;
    logic [11:0] d_csr_sel_i;
    logic [31:0] x_csr_write_value_i;
    logic [31:0] csr_time_o;
    logic [31:0] csr_timer_period_o;
    logic [63:0] csr_cycles_o;

    modport master (
        output x_stall_i, x_kill_i, d_is_csr_i, d_csr_sel_i, x_csr_write_value_i,
        input  csr_time_o, csr_timer_period_o, csr_cycles_o
    );

    modport slave (
        input  x_stall_i, x_kill_i, d_is_csr_i, d_csr_sel_i, x_csr_write_value_i,
        output csr_time_o, csr_timer_period_o, csr_cycles_o
    );
endinterface

// File: rtl/urv_timer_prescaler.sv
// Divides the core clock by DIV: counts 0..DIV-1, strobes pre_tick_o while at DIV-1.
// Latency: pre_tick_o is combinational from the count register; no backpressure.
module urv_timer_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic pre_tick_o
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign pre_tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || pre_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/urv_timer.sv
// uRV system timer: periodic one-cycle tick_o every period*DIV clocks plus cycle counter for CSR reads.
// Latency: tick_o registered one cycle after terminal pre_tick; CSR writes visible next cycle. Optional: URV_TIMER_CYCLE_COUNTER_EN.
module urv_timer
    import urv_timer_pkg::*;
#(
    parameter int g_clock_frequency = 100000000,
    parameter int g_timer_frequency = 1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    urv_timer_if.slave       csr_if,
    output logic             tick_o
);
    localparam int DIV = g_clock_frequency / g_timer_frequency;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("urv_timer: clock/timer frequency ratio must be at least 2");
        end
    endgenerate

    logic        period_wr;
    logic        pre_tick;
    logic [31:0] period_q, period_d;
    logic [31:0] count_q, count_d;
    logic        tick_q, tick_d;

    assign period_wr = is_period_write(csr_if.x_stall_i, csr_if.x_kill_i,
                                       csr_if.d_is_csr_i, csr_if.d_csr_sel_i);

    urv_timer_prescaler #(.DIV(DIV)) u_prescaler (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (period_wr),
        .pre_tick_o (pre_tick)
    );

    // A period write restarts the whole count and suppresses any coincident tick.
    always_comb begin
        period_d = period_q;
        count_d  = count_q;
        tick_d   = 1'b0;
        if (period_wr) begin
            period_d = csr_if.x_csr_write_value_i;
            count_d  = '0;
        end else if (pre_tick && (period_q != '0)) begin
            if (count_q == period_q - 32'd1) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_q <= '0;
            count_q  <= '0;
            tick_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            count_q  <= count_d;
            tick_q   <= tick_d;
        end
    end

    assign tick_o                    = tick_q;
    assign csr_if.csr_time_o         = count_q;
    assign csr_if.csr_timer_period_o = period_q;

`ifdef URV_TIMER_CYCLE_COUNTER_EN
    logic [63:0] cycles_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_q + 64'd1;
        end
    end

    assign csr_if.csr_cycles_o = cycles_q;
`else
    assign csr_if.csr_cycles_o = '0;
`endif
endmodule

// File: tb/tb_urv_timer.sv
// Directed bench for urv_timer with DIV=10 (10 Hz core clock, 1 Hz timer).
module tb_urv_timer;
    import urv_timer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick;
    int   n_total = 0;
    int   n_bad   = 0;

    urv_timer_if tif();

    urv_timer #(
        .g_clock_frequency (10),
        .g_timer_frequency (1)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .csr_if (tif),
        .tick_o (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic csr_write(input logic [11:0] sel, input logic [31:0] val,
                             input logic stall, input logic kill);
        tif.d_is_csr_i          = 1'b1;
        tif.d_csr_sel_i         = sel;
        tif.x_csr_write_value_i = val;
        tif.x_stall_i           = stall;
        tif.x_kill_i            = kill;
        step();
        tif.d_is_csr_i          = 1'b0;
        tif.x_stall_i           = 1'b0;
        tif.x_kill_i            = 1'b0;
        tif.x_csr_write_value_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Runs n cycles; returns tick count and the cycle index (1-based) of the first tick, 0 if none.
    task automatic run_count(input int n, output int nt, output int first);
        nt    = 0;
        first = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (tick === 1'b1) begin
                nt++;
                if (first == 0) first = k;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nt;
        int first;
        int pos[3];

        tif.x_stall_i = 1'b0;
        tif.x_kill_i  = 1'b0;
        tif.d_is_csr_i = 1'b0;
        tif.d_csr_sel_i = '0;
        tif.x_csr_write_value_i = '0;

        // Reset state
        rst = 1'b1;
        step(); step(); step();
        chk("rst_tick",   {63'd0, tick}, 64'd0);
        chk("rst_time",   {32'd0, tif.csr_time_o}, 64'd0);
        chk("rst_period", {32'd0, tif.csr_timer_period_o}, 64'd0);
        chk("rst_cycles", tif.csr_cycles_o, 64'd0);
        rst = 1'b0;

        // Idle with period 0: no ticks, count holds
        run_count(100, nt, first);
        chk("idle_ticks", 64'(nt), 64'd0);
        chk("idle_time",  {32'd0, tif.csr_time_o}, 64'd0);
`ifdef URV_TIMER_CYCLE_COUNTER_EN
        chk("idle_cycles", tif.csr_cycles_o, 64'd100);
`else
        chk("idle_cycles", tif.csr_cycles_o, 64'd0);
`endif

        // Period 3: ticks at 30, 60, 90 clocks after the write
        csr_write(CSR_ID_TIMER_PERIOD, 32'd3, 1'b0, 1'b0);
        chk("p3_period", {32'd0, tif.csr_timer_period_o}, 64'd3);
        chk("p3_time0",  {32'd0, tif.csr_time_o}, 64'd0);
        nt = 0;
        for (int k = 1; k <= 90; k++) begin
            step();
            if (tick === 1'b1) begin
                if (nt < 3) pos[nt] = k;
                nt++;
            end
            if (k == 10) chk("p3_time_k10", {32'd0, tif.csr_time_o}, 64'd1);
            if (k == 20) chk("p3_time_k20", {32'd0, tif.csr_time_o}, 64'd2);
            if (k == 29) chk("p3_time_k29", {32'd0, tif.csr_time_o}, 64'd2);
            if (k == 30) chk("p3_time_k30", {32'd0, tif.csr_time_o}, 64'd0);
            if (k == 31) chk("p3_width",    {63'd0, tick}, 64'd0);
        end
        chk("p3_nticks", 64'(nt), 64'd3);
        if (nt >= 3) begin
            chk("p3_first",  64'(pos[0]), 64'd30);
            chk("p3_second", 64'(pos[1]), 64'd60);
            chk("p3_third",  64'(pos[2]), 64'd90);
        end

        // Stalled and killed writes are dropped
        do_reset();
        csr_write(CSR_ID_TIMER_PERIOD, 32'd3, 1'b1, 1'b0);
        chk("stall_period", {32'd0, tif.csr_timer_period_o}, 64'd0);
        run_count(40, nt, first);
        chk("stall_ticks", 64'(nt), 64'd0);
        csr_write(CSR_ID_TIMER_PERIOD, 32'd3, 1'b0, 1'b1);
        chk("kill_period", {32'd0, tif.csr_timer_period_o}, 64'd0);
        run_count(40, nt, first);
        chk("kill_ticks", 64'(nt), 64'd0);

        // Read-only CSRs ignore writes
        csr_write(CSR_ID_TIMER, 32'd3, 1'b0, 1'b0);
        csr_write(CSR_ID_CYCLESL, 32'd7, 1'b0, 1'b0);
        chk("ro_period", {32'd0, tif.csr_timer_period_o}, 64'd0);
        chk("ro_time",   {32'd0, tif.csr_time_o}, 64'd0);

        // Write coincident with terminal pre_tick wins
        do_reset();
        csr_write(CSR_ID_TIMER_PERIOD, 32'd3, 1'b0, 1'b0);
        repeat (29) step();
        chk("ww_pre_time", {32'd0, tif.csr_time_o}, 64'd2);
        csr_write(CSR_ID_TIMER_PERIOD, 32'd5, 1'b0, 1'b0);
        chk("ww_tick",   {63'd0, tick}, 64'd0);
        chk("ww_time",   {32'd0, tif.csr_time_o}, 64'd0);
        chk("ww_period", {32'd0, tif.csr_timer_period_o}, 64'd5);
        run_count(50, nt, first);
        chk("ww_nticks", 64'(nt), 64'd1);
        chk("ww_first",  64'(first), 64'd50);

        // Reset in the cycle before a tick drops it
        do_reset();
        csr_write(CSR_ID_TIMER_PERIOD, 32'd3, 1'b0, 1'b0);
        repeat (29) step();
        chk("mr_pre_time", {32'd0, tif.csr_time_o}, 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_tick",   {63'd0, tick}, 64'd0);
        chk("mr_time",   {32'd0, tif.csr_time_o}, 64'd0);
        chk("mr_period", {32'd0, tif.csr_timer_period_o}, 64'd0);
        chk("mr_cycles", tif.csr_cycles_o, 64'd0);
        run_count(40, nt, first);
        chk("mr_ticks", 64'(nt), 64'd0);

        // Cycle counter carry into the upper word
`ifdef URV_TIMER_CYCLE_COUNTER_EN
        force dut.cycles_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        chk("cy_forced", tif.csr_cycles_o, 64'h0000_0000_FFFF_FFFF);
        release dut.cycles_q;
        step();
        chk("cy_carry", tif.csr_cycles_o, 64'h0000_0001_0000_0000);
        step();
        chk("cy_next",  tif.csr_cycles_o, 64'h0000_0001_0000_0001);
`else
        repeat (5) step();
        chk("cy_tied", tif.csr_cycles_o, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
